fp_adder_driver: RTL and testbench

- Initiator for the double-precision floating-point adder's store/acknowledgment handshake.
- Accepts one operand pair from an upstream valid/ready stream, then sends A and B to the adder in that order.
- Collects SUM from the adder and presents it downstream with valid/ready.
- Adds a per-phase response timeout and a completed-operation counter. Sits between the Halley-method SQRT sequencer and the adder.

---
 rtl/fp_adder_driver.sv | 196 +++++++++++++++++++
 tb/tb_fp_adder_driver.sv | 421 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_adder_driver.sv
// fp_adder_driver: takes one operand pair from an upstream valid/ready stream,
// sends A then B to the double-precision adder over store/acknowledgment
// handshakes, collects SUM and hands it downstream with valid/ready.
// Each adder-facing phase has a cycle budget. If the budget runs out, the
// operation is aborted and a flagged quiet-NaN result is delivered instead.
module fp_adder_driver #(
    parameter int unsigned TIMEOUT_CYCLES = 64,
    parameter int unsigned CNT_WIDTH      = 16
) (
    input  logic                 Clock,
    input  logic                 Reset,
    input  logic                 op_valid,
    output logic                 op_ready,
    input  logic [63:0]          op_a,
    input  logic [63:0]          op_b,
    output logic [63:0]          A,
    output logic                 A_store_bit,
    input  logic                 A_acknowledgment,
    output logic [63:0]          B,
    output logic                 B_store_bit,
    input  logic                 B_acknowledgment,
    input  logic [63:0]          SUM,
    input  logic                 SUM_store_bit,
    output logic                 SUM_acknowledgment,
    output logic                 res_valid,
    input  logic                 res_ready,
    output logic [63:0]          res_sum,
    output logic                 res_err,
    output logic [CNT_WIDTH-1:0] done_count
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        SEND_A   = 3'd1,
        SEND_B   = 3'd2,
        WAIT_SUM = 3'd3,
        HOLD     = 3'd4
    } state_t;

    // The phase counter only has to reach TIMEOUT_CYCLES-1.
    localparam int unsigned TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [63:0]   ABORT_VALUE = 64'hFFF8000000000000;

    state_t                 state_q, state_d;
    logic [TW-1:0]          tmo_q, tmo_d;
    logic                   op_ready_q, op_ready_d;
    logic [63:0]            a_q, a_d;
    logic [63:0]            b_q, b_d;
    logic                   a_stb_q, a_stb_d;
    logic                   b_stb_q, b_stb_d;
    logic                   sum_ack_q, sum_ack_d;
    logic                   res_valid_q, res_valid_d;
    logic [63:0]            res_sum_q, res_sum_d;
    logic                   res_err_q, res_err_d;
    logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;

    logic tmo_hit;
    logic abort;
    logic timed;

    // A zero budget means the phase counter never expires.
    assign tmo_hit = (TIMEOUT_CYCLES != 0) && (tmo_q == TMO_LAST);
    assign timed   = (state_q == SEND_A) || (state_q == SEND_B) || (state_q == WAIT_SUM);

    // Next-state and registered-output logic for the handshake sequencer.
    always_comb begin
        state_d     = state_q;
        op_ready_d  = op_ready_q;
        a_d         = a_q;
        b_d         = b_q;
        a_stb_d     = a_stb_q;
        b_stb_d     = b_stb_q;
        sum_ack_d   = sum_ack_q;
        res_valid_d = res_valid_q;
        res_sum_d   = res_sum_q;
        res_err_d   = res_err_q;
        cnt_d       = cnt_q;
        abort       = 1'b0;
        tmo_d       = '0;

        case (state_q)
            IDLE: begin
                if (op_valid && op_ready_q) begin
                    a_d        = op_a;
                    b_d        = op_b;
                    op_ready_d = 1'b0;
                    a_stb_d    = 1'b1;
                    state_d    = SEND_A;
                end
            end
            SEND_A: begin
                // A transfer on the expiry edge takes priority over the abort.
                if (a_stb_q && A_acknowledgment) begin
                    a_stb_d = 1'b0;
                    b_stb_d = 1'b1;
                    state_d = SEND_B;
                end else begin
                    abort = tmo_hit;
                end
            end
            SEND_B: begin
                if (b_stb_q && B_acknowledgment) begin
                    b_stb_d   = 1'b0;
                    sum_ack_d = 1'b1;
                    state_d   = WAIT_SUM;
                end else begin
                    abort = tmo_hit;
                end
            end
            WAIT_SUM: begin
                if (SUM_store_bit && sum_ack_q) begin
                    res_sum_d   = SUM;
                    sum_ack_d   = 1'b0;
                    res_valid_d = 1'b1;
                    res_err_d   = 1'b0;
                    state_d     = HOLD;
                end else begin
                    abort = tmo_hit;
                end
            end
            HOLD: begin
                if (res_ready) begin
                    res_valid_d = 1'b0;
                    res_err_d   = 1'b0;
                    cnt_d       = cnt_q + CNT_WIDTH'(1);
                    op_ready_d  = 1'b1;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d    = IDLE;
                op_ready_d = 1'b1;
            end
        endcase

        // An abort drops every adder-facing strobe and delivers a flagged qNaN.
        if (abort) begin
            a_stb_d     = 1'b0;
            b_stb_d     = 1'b0;
            sum_ack_d   = 1'b0;
            res_sum_d   = ABORT_VALUE;
            res_err_d   = 1'b1;
            res_valid_d = 1'b1;
            state_d     = HOLD;
        end

        // The phase counter restarts on every state change.
        if (state_d == state_q && timed) begin
            tmo_d = tmo_q + TW'(1);
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q     <= IDLE;
            tmo_q       <= '0;
            op_ready_q  <= 1'b1;
            a_q         <= '0;
            b_q         <= '0;
            a_stb_q     <= 1'b0;
            b_stb_q     <= 1'b0;
            sum_ack_q   <= 1'b0;
            res_valid_q <= 1'b0;
            res_sum_q   <= '0;
            res_err_q   <= 1'b0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            tmo_q       <= tmo_d;
            op_ready_q  <= op_ready_d;
            a_q         <= a_d;
            b_q         <= b_d;
            a_stb_q     <= a_stb_d;
            b_stb_q     <= b_stb_d;
            sum_ack_q   <= sum_ack_d;
            res_valid_q <= res_valid_d;
            res_sum_q   <= res_sum_d;
            res_err_q   <= res_err_d;
            cnt_q       <= cnt_d;
        end
    end

    assign op_ready           = op_ready_q;
    assign A                  = a_q;
    assign B                  = b_q;
    assign A_store_bit        = a_stb_q;
    assign B_store_bit        = b_stb_q;
    assign SUM_acknowledgment = sum_ack_q;
    assign res_valid          = res_valid_q;
    assign res_sum            = res_sum_q;
    assign res_err            = res_err_q;
    assign done_count         = cnt_q;

endmodule

// File: tb/tb_fp_adder_driver.sv
// Bench for fp_adder_driver. It runs two instances: one with default
// parameters and one with an 8-cycle budget and a 3-bit counter. Both share
// the same inputs. A behavioural adder follows whichever instance is selected.
module tb_fp_adder_driver;

    localparam logic [63:0] QNAN = 64'hFFF8000000000000;

    logic        Clock = 1'b0;
    logic        Reset;
    logic        op_valid, res_ready, A_ack, B_ack;
    logic [63:0] op_a, op_b;
    logic [63:0] SUM;
    logic        SUM_stb;

    logic        rdy_0, ast_0, bst_0, sak_0, rv_0, err_0;
    logic [63:0] A_0, B_0, rs_0;
    logic [15:0] dc_0;
    logic        rdy_1, ast_1, bst_1, sak_1, rv_1, err_1;
    logic [63:0] A_1, B_1, rs_1;
    logic [2:0]  dc_1;

    fp_adder_driver dut0 (
        .Clock(Clock), .Reset(Reset), .op_valid(op_valid), .op_ready(rdy_0),
        .op_a(op_a), .op_b(op_b), .A(A_0), .A_store_bit(ast_0), .A_acknowledgment(A_ack),
        .B(B_0), .B_store_bit(bst_0), .B_acknowledgment(B_ack), .SUM(SUM),
        .SUM_store_bit(SUM_stb), .SUM_acknowledgment(sak_0), .res_valid(rv_0),
        .res_ready(res_ready), .res_sum(rs_0), .res_err(err_0), .done_count(dc_0)
    );

    fp_adder_driver #(.TIMEOUT_CYCLES(8), .CNT_WIDTH(3)) dut1 (
        .Clock(Clock), .Reset(Reset), .op_valid(op_valid), .op_ready(rdy_1),
        .op_a(op_a), .op_b(op_b), .A(A_1), .A_store_bit(ast_1), .A_acknowledgment(A_ack),
        .B(B_1), .B_store_bit(bst_1), .B_acknowledgment(B_ack), .SUM(SUM),
        .SUM_store_bit(SUM_stb), .SUM_acknowledgment(sak_1), .res_valid(rv_1),
        .res_ready(res_ready), .res_sum(rs_1), .res_err(err_1), .done_count(dc_1)
    );

    // Selected-instance view used by the adder model and the checks.
    logic        sel;
    logic        m_rdy, m_ast, m_bst, m_sak, m_rv, m_err;
    logic [63:0] m_A, m_B, m_rs;
    logic [15:0] m_dc;
    assign m_rdy = sel ? rdy_1 : rdy_0;
    assign m_ast = sel ? ast_1 : ast_0;
    assign m_bst = sel ? bst_1 : bst_0;
    assign m_sak = sel ? sak_1 : sak_0;
    assign m_rv  = sel ? rv_1  : rv_0;
    assign m_err = sel ? err_1 : err_0;
    assign m_A   = sel ? A_1   : A_0;
    assign m_B   = sel ? B_1   : B_0;
    assign m_rs  = sel ? rs_1  : rs_0;
    assign m_dc  = sel ? {13'd0, dc_1} : dc_0;

    always #5 Clock = ~Clock;

    function automatic logic [63:0] fadd(input logic [63:0] a, input logic [63:0] b);
        return $realtobits($bitstoreal(a) + $bitstoreal(b));
    endfunction

    // Finite, moderately sized doubles, so that the sums stay ordinary numbers.
    function automatic logic [63:0] rnd_op();
        logic [63:0] r;
        r = {$urandom, $urandom};
        r[62:52] = 11'(1013 + $urandom_range(0, 20));
        return r;
    endfunction

    // Behavioural adder. It captures A, then B, and offers A+B on SUM.
    // In random mode the SUM delay varies.
    logic        sum_en, rnd, flush, pend;
    logic [63:0] a_cap;
    int          na;
    wire         bx = m_bst && B_ack;
    always @(posedge Clock) begin
        if (Reset) begin
            pend <= 1'b0; SUM_stb <= 1'b0; na <= 0;
        end else begin
            if (m_ast && A_ack) begin a_cap <= m_A; na <= na + 1; end
            if (flush) begin
                pend <= 1'b0; SUM_stb <= 1'b0;
            end else if (SUM_stb) begin
                if (m_sak) SUM_stb <= 1'b0;
            end else if (pend || bx) begin
                if (bx) SUM <= fadd(a_cap, m_B);
                if (sum_en && (!rnd || $urandom_range(0, 1) == 1)) begin
                    SUM_stb <= 1'b1; pend <= 1'b0;
                end else begin
                    pend <= 1'b1;
                end
            end
        end
    end

    int cyc = 0;
    always @(posedge Clock) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    task automatic step();
        @(posedge Clock); @(negedge Clock);
    endtask

    task automatic do_reset(input logic s);
        sel = s; Reset = 1'b1; op_valid = 1'b0; res_ready = 1'b0; A_ack = 1'b1; B_ack = 1'b1;
        sum_en = 1'b1; rnd = 1'b0; flush = 1'b0; op_a = '0; op_b = '0;
        step(); step();
        Reset = 1'b0;
    endtask

    task automatic wait_res(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 60; i++) begin
            if (m_rv) begin ok = 1'b1; break; end
            step();
        end
    endtask

    task automatic test_reset();
        do_reset(1'b0);
        total++;
        if ({rdy_0, ast_0, bst_0, sak_0, rv_0, err_0} !== 6'b100000) begin
            bad++; $display("FAIL reset_ctl0 got=%b exp=100000", {rdy_0, ast_0, bst_0, sak_0, rv_0, err_0});
        end
        total++;
        if ({A_0, B_0, rs_0, dc_0} !== '0) begin
            bad++; $display("FAIL reset_data0 got A=%h B=%h sum=%h cnt=%0d exp all zero", A_0, B_0, rs_0, dc_0);
        end
        total++;
        if ({rdy_1, ast_1, bst_1, sak_1, rv_1, err_1, dc_1} !== 9'b100000000) begin
            bad++; $display("FAIL reset_ctl1 got=%b exp=100000000", {rdy_1, ast_1, bst_1, sak_1, rv_1, err_1, dc_1});
        end
    endtask

    task automatic test_basic();
        do_reset(1'b0);
        op_a = 64'h3FF0000000000000; op_b = 64'h4000000000000000; op_valid = 1'b1;
        step(); op_valid = 1'b0; op_a = '0; op_b = '0;
        total++;
        if ({m_ast, m_bst, m_rdy} !== 3'b100 || m_A !== 64'h3FF0000000000000 || m_B !== 64'h4000000000000000) begin
            bad++; $display("FAIL basic_e0 got stb=%b A=%h B=%h exp stb=100", {m_ast, m_bst, m_rdy}, m_A, m_B);
        end
        step();
        total++;
        if ({m_ast, m_bst, m_sak} !== 3'b010) begin
            bad++; $display("FAIL basic_e1 got=%b exp=010", {m_ast, m_bst, m_sak});
        end
        step();
        total++;
        if ({m_ast, m_bst, m_sak, m_rv} !== 4'b0010) begin
            bad++; $display("FAIL basic_e2 got=%b exp=0010", {m_ast, m_bst, m_sak, m_rv});
        end
        step();
        total++;
        if (m_rv !== 1'b1 || m_rs !== 64'h4008000000000000 || m_err !== 1'b0 || m_sak !== 1'b0) begin
            bad++; $display("FAIL basic_e3 got rv=%b sum=%h err=%b ack=%b exp rv=1 sum=4008000000000000", m_rv, m_rs, m_err, m_sak);
        end
        res_ready = 1'b1; step(); res_ready = 1'b0;
        total++;
        if (m_rv !== 1'b0 || m_rdy !== 1'b1 || m_dc !== 16'd1) begin
            bad++; $display("FAIL basic_done got rv=%b rdy=%b cnt=%0d exp 0 1 1", m_rv, m_rdy, m_dc);
        end
    endtask

    task automatic test_ack_stall();
        logic [63:0] a, b;
        bit ok;
        int errs;
        do_reset(1'b0);
        a = rnd_op(); b = rnd_op();
        A_ack = 1'b0; op_a = a; op_b = b; op_valid = 1'b1;
        step(); op_valid = 1'b0; op_a = rnd_op();
        errs = 0;
        for (int i = 0; i < 11; i++) begin
            if (m_ast !== 1'b1 || m_A !== a || m_bst !== 1'b0) errs++;
            step();
        end
        total++;
        if (errs != 0) begin
            bad++; $display("FAIL stall_hold got %0d bad cycles exp 0", errs);
        end
        A_ack = 1'b1; step();
        total++;
        if (m_ast !== 1'b0 || m_bst !== 1'b1 || na != 1) begin
            bad++; $display("FAIL stall_xfer got ast=%b bst=%b xfers=%0d exp 0 1 1", m_ast, m_bst, na);
        end
        wait_res(ok);
        total++;
        if (!ok || m_rs !== fadd(a, b) || m_err !== 1'b0) begin
            bad++; $display("FAIL stall_result got ok=%b sum=%h err=%b exp sum=%h", ok, m_rs, m_err, fadd(a, b));
        end
        res_ready = 1'b1; step(); res_ready = 1'b0;
    endtask

    task automatic test_backpressure();
        logic [63:0] a, b, s0;
        bit ok;
        int errs;
        do_reset(1'b0);
        a = rnd_op(); b = rnd_op();
        op_a = a; op_b = b; op_valid = 1'b1;
        step(); op_valid = 1'b0;
        wait_res(ok);
        s0 = m_rs;
        total++;
        if (!ok || s0 !== fadd(a, b)) begin
            bad++; $display("FAIL bp_result got ok=%b sum=%h exp %h", ok, s0, fadd(a, b));
        end
        errs = 0;
        for (int i = 0; i < 7; i++) begin
            op_valid = 1'b1; op_a = rnd_op(); op_b = rnd_op();
            if (m_rv !== 1'b1 || m_rs !== s0 || m_rdy !== 1'b0 || m_A !== a || m_dc !== 16'd0) errs++;
            step();
        end
        total++;
        if (errs != 0) begin
            bad++; $display("FAIL bp_hold got %0d bad cycles exp 0", errs);
        end
        op_valid = 1'b0; res_ready = 1'b1; step(); res_ready = 1'b0;
        total++;
        if (m_dc !== 16'd1 || m_rv !== 1'b0 || m_rdy !== 1'b1 || m_A !== a || m_B !== b) begin
            bad++; $display("FAIL bp_release got cnt=%0d rv=%b rdy=%b A=%h exp 1 0 1 %h", m_dc, m_rv, m_rdy, m_A, a);
        end
    endtask

    task automatic test_timeout();
        logic [63:0] a, b;
        bit ok;
        int errs;
        do_reset(1'b1);
        sum_en = 1'b0;
        op_a = rnd_op(); op_b = rnd_op(); op_valid = 1'b1;
        step(); op_valid = 1'b0;
        step(); step();
        errs = 0;
        for (int i = 0; i < 7; i++) begin
            if (m_sak !== 1'b1 || m_rv !== 1'b0) errs++;
            step();
        end
        total++;
        if (errs != 0 || m_sak !== 1'b1 || m_rv !== 1'b0) begin
            bad++; $display("FAIL tmo_early got %0d bad cycles ack=%b rv=%b exp ack=1 rv=0", errs, m_sak, m_rv);
        end
        step();
        total++;
        if (m_sak !== 1'b0 || m_rv !== 1'b1 || m_rs !== QNAN || m_err !== 1'b1) begin
            bad++; $display("FAIL tmo_abort got ack=%b rv=%b sum=%h err=%b exp 0 1 %h 1", m_sak, m_rv, m_rs, m_err, QNAN);
        end
        flush = 1'b1; res_ready = 1'b1; step(); flush = 1'b0; res_ready = 1'b0; sum_en = 1'b1;
        total++;
        if (m_dc !== 16'd1 || m_err !== 1'b0) begin
            bad++; $display("FAIL tmo_count got cnt=%0d err=%b exp 1 0", m_dc, m_err);
        end
        // The A transfer lands on the very edge at which the budget would expire.
        a = rnd_op(); b = rnd_op();
        A_ack = 1'b0; op_a = a; op_b = b; op_valid = 1'b1;
        step(); op_valid = 1'b0;
        for (int i = 0; i < 7; i++) step();
        A_ack = 1'b1; step();
        total++;
        if (m_bst !== 1'b1 || m_rv !== 1'b0) begin
            bad++; $display("FAIL tmo_edge got bst=%b rv=%b exp 1 0", m_bst, m_rv);
        end
        wait_res(ok);
        total++;
        if (!ok || m_rs !== fadd(a, b) || m_err !== 1'b0) begin
            bad++; $display("FAIL tmo_after got ok=%b sum=%h err=%b exp %h 0", ok, m_rs, m_err, fadd(a, b));
        end
        res_ready = 1'b1; step(); res_ready = 1'b0;
        total++;
        if (m_dc !== 16'd2) begin
            bad++; $display("FAIL tmo_count2 got %0d exp 2", m_dc);
        end
    endtask

    task automatic test_reset_mid();
        bit ok;
        do_reset(1'b0);
        op_a = rnd_op(); op_b = rnd_op(); op_valid = 1'b1;
        step(); op_valid = 1'b0;
        wait_res(ok);
        res_ready = 1'b1; step(); res_ready = 1'b0;
        total++;
        if (!ok || m_dc !== 16'd1) begin
            bad++; $display("FAIL rmid_pre got ok=%b cnt=%0d exp 1", ok, m_dc);
        end
        B_ack = 1'b0;
        op_a = rnd_op(); op_b = rnd_op(); op_valid = 1'b1;
        step(); op_valid = 1'b0; step();
        total++;
        if (m_bst !== 1'b1) begin
            bad++; $display("FAIL rmid_sendb got bst=%b exp 1", m_bst);
        end
        Reset = 1'b1; step(); Reset = 1'b0; B_ack = 1'b1;
        total++;
        if ({m_rdy, m_ast, m_bst, m_sak, m_rv, m_err} !== 6'b100000 || {m_A, m_B, m_rs, m_dc} !== '0) begin
            bad++; $display("FAIL rmid_state got ctl=%b A=%h B=%h sum=%h cnt=%0d exp 100000 and zeros",
                            {m_rdy, m_ast, m_bst, m_sak, m_rv, m_err}, m_A, m_B, m_rs, m_dc);
        end
    endtask

    task automatic test_back_to_back();
        logic [63:0] exp_q[$];
        logic [63:0] e, a, b;
        int iss[$];
        int n_iss, n_res, errs;
        do_reset(1'b0);
        res_ready = 1'b1;
        n_iss = 0; n_res = 0; errs = 0;
        for (int c = 0; c < 100; c++) begin
            if (m_rv) begin
                e = exp_q.pop_front();
                if (m_rs !== e || m_err !== 1'b0) errs++;
                n_res++;
            end
            if (m_rdy && n_iss < 4) begin
                a = rnd_op(); b = rnd_op();
                op_a = a; op_b = b; op_valid = 1'b1;
                exp_q.push_back(fadd(a, b)); iss.push_back(cyc); n_iss++;
            end else begin
                op_valid = 1'b0;
            end
            step();
            if (n_res == 4) break;
        end
        res_ready = 1'b0;
        total++;
        if (n_res != 4 || errs != 0) begin
            bad++; $display("FAIL b2b_results got %0d results %0d wrong exp 4 0", n_res, errs);
        end
        total++;
        if (iss.size() != 4 || iss[1] - iss[0] != 5 || iss[2] - iss[1] != 5 || iss[3] - iss[2] != 5) begin
            bad++; $display("FAIL b2b_interval got issues=%0d exp 4 at 5-cycle spacing", iss.size());
        end
        total++;
        if (m_dc !== 16'd4) begin
            bad++; $display("FAIL b2b_count got %0d exp 4", m_dc);
        end
    endtask

    task automatic test_wrap();
        bit ok;
        int errs;
        logic [63:0] a, b;
        do_reset(1'b1);
        errs = 0;
        for (int i = 0; i < 9; i++) begin
            a = rnd_op(); b = rnd_op();
            op_a = a; op_b = b; op_valid = 1'b1;
            step(); op_valid = 1'b0;
            wait_res(ok);
            if (!ok || m_rs !== fadd(a, b)) errs++;
            res_ready = 1'b1; step(); res_ready = 1'b0;
            if (m_dc !== 16'((i + 1) % 8)) errs++;
        end
        total++;
        if (errs != 0 || m_dc !== 16'd1) begin
            bad++; $display("FAIL wrap got %0d errors cnt=%0d exp 0 1", errs, m_dc);
        end
    endtask

    task automatic test_random();
        logic [63:0] exp_q[$];
        logic [63:0] e, a, b;
        int n_iss, n_res, errs;
        do_reset(1'b0);
        rnd = 1'b1;
        n_iss = 0; n_res = 0; errs = 0;
        for (int c = 0; c < 3000; c++) begin
            A_ack = 1'($urandom_range(0, 1)); B_ack = 1'($urandom_range(0, 1));
            res_ready = 1'($urandom_range(0, 1));
            if (m_rv && res_ready) begin
                e = exp_q.pop_front();
                if (m_rs !== e || m_err !== 1'b0) errs++;
                n_res++;
            end
            if (m_rdy && n_iss < 30 && $urandom_range(0, 1) == 1) begin
                a = rnd_op(); b = rnd_op();
                op_a = a; op_b = b; op_valid = 1'b1;
                exp_q.push_back(fadd(a, b)); n_iss++;
            end else begin
                op_valid = 1'b0; op_a = rnd_op(); op_b = rnd_op();
            end
            step();
            if (n_res == 30) break;
        end
        res_ready = 1'b0; rnd = 1'b0;
        total++;
        if (n_res != 30 || errs != 0) begin
            bad++; $display("FAIL rand_results got %0d results %0d wrong exp 30 0", n_res, errs);
        end
        total++;
        if (m_dc !== 16'd30) begin
            bad++; $display("FAIL rand_count got %0d exp 30", m_dc);
        end
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        sel = 1'b0; Reset = 1'b1; op_valid = 1'b0; res_ready = 1'b0; A_ack = 1'b0; B_ack = 1'b0;
        sum_en = 1'b1; rnd = 1'b0; flush = 1'b0; op_a = '0; op_b = '0;
        @(negedge Clock);
        test_reset();
        test_basic();
        test_ack_stall();
        test_backpressure();
        test_timeout();
        test_reset_mid();
        test_back_to_back();
        test_wrap();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
